// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU operation encodings and decode helpers used by the issue controller
// and its arithmetic unit.
package mdu_issue_ctrl_pkg;

  localparam logic [3:0] MDU_NOOP  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

  // Unlisted encodings decode as NOOP.
  function automatic logic is_mdu_op(logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MFLO);
  endfunction

  function automatic logic is_long_op(logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// E-stage issue bus between the pipeline (master) and the MDU issue controller (slave).
interface mdu_issue_ctrl_if;

  logic        i_valid;
  logic [3:0]  i_op;
  logic [31:0] i_rs;
  logic [31:0] i_rt;
  logic        i_cancel;
  logic        o_stall;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;
  logic [31:0] o_rdata;

  modport master (
    output i_valid, i_op, i_rs, i_rt, i_cancel,
    input  o_stall, o_busy, o_done, o_hi, o_lo, o_rdata
  );

  modport slave (
    input  i_valid, i_op, i_rs, i_rt, i_cancel,
    output o_stall, o_busy, o_done, o_hi, o_lo, o_rdata
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit {HI,LO} result for MULT/MULTU/DIV/DIVU
// plus a divide-by-zero flag.
module mdu_arith
  import mdu_issue_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, den_s, den_u;
  logic [31:0] mag_q, mag_r, sq, sr, uq, ur;

  always_comb begin
    prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    prod_u = {32'd0, rs} * {32'd0, rt};

    div_zero = is_div_op(op) && (rt == 32'd0);

    // Signed divide on magnitudes; a zero divisor is replaced to keep the divider defined.
    abs_a = rs[31] ? (32'd0 - rs) : rs;
    abs_b = rt[31] ? (32'd0 - rt) : rt;
    den_s = (rt == 32'd0) ? 32'd1 : abs_b;
    den_u = (rt == 32'd0) ? 32'd1 : rt;
    mag_q = abs_a / den_s;
    mag_r = abs_a % den_s;
    sq    = (rs[31] ^ rt[31]) ? (32'd0 - mag_q) : mag_q;
    sr    = rs[31] ? (32'd0 - mag_r) : mag_r;
    uq    = rs / den_u;
    ur    = rs % den_u;

    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV:   result = {sr, sq};
      MDU_DIVU:  result = {ur, uq};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: issues multi-cycle MULT/DIV, holds the E stage while busy,
// and owns the architectural HI/LO registers.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mdu_issue_ctrl_if.slave  bus
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] MultCnt = 4'(MULT_LAT - 1);
  localparam logic [3:0] DivCnt  = 4'(DIV_LAT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] hi_q, lo_q, sh_hi_q, sh_lo_q;

  logic [63:0] arith_result;
  logic        arith_div_zero;
  logic        stall, accepted;

  mdu_arith u_arith (
    .op       (bus.i_op),
    .rs       (bus.i_rs),
    .rt       (bus.i_rt),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  always_comb begin
    stall    = bus.i_valid && is_mdu_op(bus.i_op) && (state_q == StBusy);
    accepted = bus.i_valid && !bus.i_cancel && !stall;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accepted) begin
            if (is_long_op(bus.i_op)) begin
              state_q <= StBusy;
              cnt_q   <= is_div_op(bus.i_op) ? DivCnt : MultCnt;
              // Divide-by-zero commits the current HI/LO, i.e. leaves them unchanged.
              if (arith_div_zero) begin
                sh_hi_q <= hi_q;
                sh_lo_q <= lo_q;
              end else begin
                sh_hi_q <= arith_result[63:32];
                sh_lo_q <= arith_result[31:0];
              end
            end else if (bus.i_op == MDU_MTHI) begin
              hi_q <= bus.i_rs;
            end else if (bus.i_op == MDU_MTLO) begin
              lo_q <= bus.i_rs;
            end
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            hi_q    <= sh_hi_q;
            lo_q    <= sh_lo_q;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.o_stall = stall;
    bus.o_busy  = (state_q == StBusy);
    bus.o_done  = (state_q == StBusy) && (cnt_q == 4'd0);
    bus.o_hi    = hi_q;
    bus.o_lo    = lo_q;
    case (bus.i_op)
      MDU_MFHI: bus.o_rdata = hi_q;
      MDU_MFLO: bus.o_rdata = lo_q;
      default:  bus.o_rdata = 32'd0;
    endcase
  end

endmodule

// File: doc/mdu_issue_ctrl.md
MDU_ISSUE_CTRL -- requirements
Module: mdu_issue_ctrl

Interface
REQ-001 Parameter MULT_LAT, default 5, busy cycles for MULT/MULTU (legal range 1..15).
REQ-002 Parameter DIV_LAT, default 10, busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  E-stage instruction valid.
REQ-006 i_op  input  4  MDU operation: NOOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO.
REQ-007 i_rs  input  32  operand A; MTHI/MTLO source.
REQ-008 i_rt  input  32  operand B.
REQ-009 i_cancel  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-010 o_stall  output  1  hold E stage and upstream.
REQ-011 o_busy  output  1  operation in flight.
REQ-012 o_done  output  1  one-cycle pulse in the commit cycle.
REQ-013 o_hi, o_lo  output  32 each  architectural HI/LO.
REQ-014 o_rdata  output  32  MFHI/MFLO read data.

Function
REQ-015 States IDLE and BUSY only; o_busy SHALL be 1 exactly when state is BUSY.
REQ-016 "MDU op" = any i_op other than NOOP; "accepted" = i_valid & !i_cancel & !o_stall.
REQ-017 o_stall SHALL be i_valid & (MDU op) & BUSY, combinational; NOOP never stalls.
REQ-018 Accepted MULT/MULTU/DIV/DIVU in IDLE: at edge, state->BUSY, cnt->LAT-1, 64-bit result captured in shadow {sh_hi, sh_lo}.
REQ-019 In BUSY: cnt!=0 -> cnt decrements; cnt==0 -> HI/LO<-shadow, state->IDLE at that edge; BUSY lasts exactly LAT cycles.
REQ-020 o_done SHALL be 1 in the BUSY cycle where cnt==0, else 0.
REQ-021 MULT: signed 32x32->64, {HI,LO}=product; MULTU unsigned.
REQ-022 DIV/DIVU: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-024 Divisor zero: full DIV_LAT busy period still taken, HI/LO unchanged at commit.
REQ-025 Accepted MTHI/MTLO in IDLE write i_rs to HI/LO at edge; no BUSY entry.
REQ-026 o_rdata = HI for MFHI, LO for MFLO, 0 otherwise, combinational from architectural regs; value meaningful only when o_stall=0.
REQ-027 MFHI/MFLO in the cycle after commit SHALL read the new value.
REQ-028 i_cancel suppresses issue and MTHI/MTLO writes for that cycle; it SHALL NOT abort an in-flight operation.
REQ-029 Stalled instructions have no side effect; re-presentation after stall drops is treated as fresh.
REQ-030 i_op outside listed encodings treated as NOOP.

Reset
REQ-031 reset low asynchronously forces state=IDLE, cnt=0, HI=LO=0, shadow=0.
REQ-032 Output values during reset: o_stall=0, o_busy=0, o_done=0, o_rdata=0 (given i_op), o_hi=o_lo=0.
REQ-033 Reset mid-operation discards the in-flight result; no commit after release.
REQ-034 Deassertion is synchronous-release-safe: first edge after reset high may accept an op.

Structure
REQ-035 i_op encodings (`MDU_NOOP`..`MDU_MFLO`) live in the shared macro file; MULT/MULTU/DIV/DIVU values unchanged from existing users.
REQ-036 State encoding and counter width (4 bits) are local.
REQ-037 One sub-module, mdu_arith: combinational, inputs op/rs/rt, outputs 64-bit result and div-by-zero flag.

Verification
REQ-038 Reset, then MULT rs=0xFFFFFFFF rt=2 -> o_busy high 5 cycles, o_done in 5th, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
REQ-039 DIV rs=0xFFFFFFF9(-7) rt=2, then MFLO held valid -> o_stall high 10 cycles; MFLO reads 0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-040 MTHI 0x1234 with i_cancel=1, then MFHI -> o_rdata=0; repeat without cancel -> 0x1234.
REQ-041 DIVU rt=0 with HI=5 LO=6 -> 10 busy cycles, HI=5 LO=6 after.
REQ-042 MULTU 3x4, reset pulse at busy cycle 2 -> o_busy=0 immediately, HI=LO=0, no o_done.
REQ-043 DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000 HI=0; NOOP during busy -> o_stall=0.
